// File: rtl/alarm_annunciator.sv
`default_nettype none
// ============================================================================
// Module      : alarm_annunciator
// Description : Alarm annunciator. Drives a cadenced buzzer tone and a lamp
//               while the alarm FSM raises alert_req, debounces the
//               acknowledge and snooze buttons, and returns a one-cycle
//               ack_pulse when the user acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_annunciator #(
    parameter int TONE_DIV   = 2,
    parameter int BEEP_ON    = 8,
    parameter int BEEP_OFF   = 8,
    parameter int MAX_BEEPS  = 15,
    parameter int SNOOZE_LEN = 32,
    parameter int DEBOUNCE   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alert_req,
    input  logic       ack_n,
    input  logic       snooze_n,
    output logic       buzzer,
    output logic       led,
    output logic       ack_pulse,
    output logic       escalated,
    output logic [1:0] state,
    output logic [7:0] beep_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SOUNDING = 2'd1,
        SNOOZE   = 2'd2,
        ACKED    = 2'd3
    } state_t;

    localparam int DB_W   = $clog2(DEBOUNCE + 1);
    localparam int PH_MAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TD_W   = $clog2(TONE_DIV + 1);
    // At least 4 bits so bit 3 can drive the snooze blink.
    localparam int SN_W   = (SNOOZE_LEN > 16) ? $clog2(SNOOZE_LEN) : 4;

    // ------------------------------------------------------------------
    // Button conditioning. Index 0 = acknowledge, index 1 = snooze.
    // ------------------------------------------------------------------
    logic [1:0] raw_btn;
    logic [1:0] press;
    logic [1:0] flush;

    assign raw_btn = {snooze_n, ack_n};

    // Marks when the synchronizers have shifted out their reset preset, so
    // a button held through reset is not mistaken for a fresh release.
    always_ff @(posedge clk) begin
        if (!rst_n) flush <= 2'b00;
        else        flush <= {flush[0], 1'b1};
    end

    generate
        for (genvar b = 0; b < 2; b++) begin : g_button
            logic            sync1;
            logic            sync2;
            logic            lock;
            logic            pulse;
            logic [DB_W-1:0] cnt;

            // Synchronize, then count stable-low samples; one pulse per press.
            // lock holds off counting until a real released sample is seen.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync1 <= 1'b1;
                    sync2 <= 1'b1;
                    lock  <= 1'b1;
                    cnt   <= '0;
                    pulse <= 1'b0;
                end else begin
                    sync1 <= raw_btn[b];
                    sync2 <= sync1;
                    pulse <= 1'b0;
                    if (lock) begin
                        cnt <= '0;
                        if (flush[1] && sync2) lock <= 1'b0;
                    end else if (sync2) begin
                        cnt <= '0;
                    end else if (cnt != DB_W'(DEBOUNCE)) begin
                        cnt <= cnt + DB_W'(1);
                        if (cnt == DB_W'(DEBOUNCE - 1)) pulse <= 1'b1;
                    end
                end
            end

            assign press[b] = pulse;
        end
    endgenerate

    logic ack_press;
    logic snooze_press;
    assign ack_press    = press[0];
    assign snooze_press = press[1];

    // ------------------------------------------------------------------
    // Main FSM with cadence, tone and snooze counters.
    // ------------------------------------------------------------------
    state_t          st, st_d;
    logic            phase_on, phase_on_d;
    logic            tone, tone_d;
    logic            ack_fresh, ack_fresh_d;
    logic [PH_W-1:0] ph_cnt, ph_cnt_d;
    logic [TD_W-1:0] td_cnt, td_cnt_d;
    logic [SN_W-1:0] sn_cnt, sn_cnt_d;
    logic [7:0]      beeps, beeps_d;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= IDLE;
            phase_on  <= 1'b0;
            tone      <= 1'b0;
            ack_fresh <= 1'b0;
            ph_cnt    <= '0;
            td_cnt    <= '0;
            sn_cnt    <= '0;
            beeps     <= '0;
        end else begin
            st        <= st_d;
            phase_on  <= phase_on_d;
            tone      <= tone_d;
            ack_fresh <= ack_fresh_d;
            ph_cnt    <= ph_cnt_d;
            td_cnt    <= td_cnt_d;
            sn_cnt    <= sn_cnt_d;
            beeps     <= beeps_d;
        end
    end

    // Next-state, cadence and tone sequencing.
    always_comb begin
        st_d        = st;
        phase_on_d  = phase_on;
        tone_d      = tone;
        ack_fresh_d = 1'b0;
        ph_cnt_d    = ph_cnt;
        td_cnt_d    = td_cnt;
        sn_cnt_d    = sn_cnt;
        beeps_d     = beeps;

        case (st)
            IDLE: begin
                if (alert_req) begin
                    st_d       = SOUNDING;
                    phase_on_d = 1'b1;
                    ph_cnt_d   = '0;
                    td_cnt_d   = '0;
                    tone_d     = 1'b1;
                end
            end
            SOUNDING: begin
                if (!alert_req) begin
                    st_d    = IDLE;
                    beeps_d = '0;
                end else if (ack_press) begin
                    st_d        = ACKED;
                    beeps_d     = '0;
                    ack_fresh_d = 1'b1;
                end else if (snooze_press) begin
                    st_d     = SNOOZE;
                    sn_cnt_d = '0;
                end else if (phase_on) begin
                    if (td_cnt == TD_W'(TONE_DIV - 1)) begin
                        td_cnt_d = '0;
                        tone_d   = ~tone;
                    end else begin
                        td_cnt_d = td_cnt + TD_W'(1);
                    end
                    if (ph_cnt == PH_W'(BEEP_ON - 1)) begin
                        ph_cnt_d = '0;
                        if (beeps != 8'(MAX_BEEPS)) beeps_d = beeps + 8'd1;
                        // Once escalated the ON phase simply keeps running.
                        if (beeps_d != 8'(MAX_BEEPS)) phase_on_d = 1'b0;
                    end else begin
                        ph_cnt_d = ph_cnt + PH_W'(1);
                    end
                end else begin
                    if (ph_cnt == PH_W'(BEEP_OFF - 1)) begin
                        phase_on_d = 1'b1;
                        ph_cnt_d   = '0;
                        td_cnt_d   = '0;
                        tone_d     = 1'b1;
                    end else begin
                        ph_cnt_d = ph_cnt + PH_W'(1);
                    end
                end
            end
            SNOOZE: begin
                if (!alert_req) begin
                    st_d    = IDLE;
                    beeps_d = '0;
                end else if (ack_press) begin
                    st_d        = ACKED;
                    beeps_d     = '0;
                    ack_fresh_d = 1'b1;
                end else if (sn_cnt == SN_W'(SNOOZE_LEN - 1)) begin
                    st_d       = SOUNDING;
                    phase_on_d = 1'b1;
                    ph_cnt_d   = '0;
                    td_cnt_d   = '0;
                    tone_d     = 1'b1;
                end else begin
                    sn_cnt_d = sn_cnt + SN_W'(1);
                end
            end
            ACKED: begin
                if (!alert_req) begin
                    st_d    = IDLE;
                    beeps_d = '0;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    assign buzzer     = (st == SOUNDING) && phase_on && tone;
    assign led        = (st == SOUNDING) || ((st == SNOOZE) && sn_cnt[3]);
    assign ack_pulse  = (st == ACKED) && ack_fresh;
    assign escalated  = (beeps == 8'(MAX_BEEPS));
    assign state      = st;
    assign beep_count = beeps;

endmodule
`default_nettype wire

// File: doc/alarm_annunciator.md
Name: alarm_annunciator

Overview:
Consumer side of the alarm FSM's alert output. Takes the alert level and drives a buzzer with a cadenced square-wave tone and an annunciator LED. Owns the user's acknowledge and snooze buttons, debouncing both internally. Returns a one-cycle ack_pulse to the alarm FSM so it can return to idle.

Parameters:
TONE_DIV, 2, tone half-period in clk cycles (>=1)
BEEP_ON, 8, cycles of tone per beep (>=1)
BEEP_OFF, 8, silent cycles between beeps (>=1)
MAX_BEEPS, 15, beep count at which cadence escalates to continuous tone (1..255)
SNOOZE_LEN, 32, cycles spent silent in SNOOZE (>=1)
DEBOUNCE, 4, consecutive low samples required to accept a press (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
alert_req  in  1  alert level from alarm FSM; high = alarm active
ack_n  in  1  raw acknowledge button, asynchronous, active-low
snooze_n  in  1  raw snooze button, asynchronous, active-low
buzzer  out  1  tone output
led  out  1  annunciator lamp
ack_pulse  out  1  one-cycle strobe on acknowledge
escalated  out  1  high when beep_count == MAX_BEEPS
state  out  2  IDLE=0, SOUNDING=1, SNOOZE=2, ACKED=3
beep_count  out  8  completed beeps since alert began, saturating

Behaviour:
- Reset (rst_n low at posedge) applies the following, overriding everything else, including mid-operation:
  - state=IDLE; all counters=0; beep_count=0.
  - Synchronizer and debounce flops preset to "released".
  - All outputs 0.
- Outputs are decoded combinationally from registered state and counters; there are no extra output flops.
- Button path, per button:
  - 2-flop synchronizer, then a stable-low counter.
  - The counter clears whenever the synced input is high.
  - On reaching DEBOUNCE it emits one internal press pulse and holds.
  - No further pulse until the synced input returns high.
  - Press latency from first low sample at the sync input: 2+DEBOUNCE cycles.
- IDLE:
  - alert_req high -> SOUNDING.
  - Entering SOUNDING clears the cadence and tone counters and sets phase=ON.
  - Button presses in IDLE are consumed and ignored.
- SOUNDING, priority highest first:
  - alert_req low -> IDLE.
  - ack press -> ACKED.
  - snooze press -> SNOOZE.
  - Otherwise, advance the cadence.
- Cadence:
  - ON phase lasts BEEP_ON cycles; OFF phase lasts BEEP_OFF cycles; repeat.
  - At the last ON cycle, beep_count increments, saturating at MAX_BEEPS.
  - While escalated, the OFF phase is skipped and the tone runs continuously.
- Tone:
  - Level is 1 at the first cycle of each ON phase.
  - Toggles every TONE_DIV cycles.
  - buzzer = tone level during ON phase, 0 during OFF.
- SNOOZE:
  - buzzer=0; a counter runs SNOOZE_LEN cycles.
  - alert_req low -> IDLE, immediately.
  - ack press -> ACKED.
  - Snooze press is ignored.
  - At counter expiry -> SOUNDING with a fresh cadence; beep_count is retained.
- ACKED:
  - ack_pulse=1 for exactly the first cycle in ACKED.
  - buzzer=0.
  - alert_req low -> IDLE.
  - Stays in ACKED while alert_req is high; no re-trigger.
- beep_count clears on entry to IDLE or ACKED.
- led = 1 in SOUNDING; in SNOOZE = bit 3 of the snooze counter (slow blink); 0 otherwise.
- Simultaneous events:
  - ack and snooze presses in the same cycle: ack wins.
  - alert_req falling in the same cycle as any press: IDLE wins and no ack_pulse is issued.

Test Plan:
1. Reset then alert_req=1 held, defaults -> state=1 the next cycle; buzzer 1,1,0,0,1,1,0,0 then 8×0; beep_count=1 after cycle 8.
2. alert_req held for 16 beeps -> beep_count saturates at 15; escalated=1; buzzer toggles every 2 cycles with no OFF gap.
3. In SOUNDING, ack_n low for 6 cycles -> ACKED at 2+4 cycles after the first low; ack_pulse high exactly 1 cycle; buzzer=0; beep_count=0. Drop alert_req -> IDLE.
4. In SOUNDING, snooze_n pressed -> SNOOZE with buzzer=0 for 32 cycles, then SOUNDING with beep_count retained. A second snooze press held without release gives no extra pulse.
5. ack_n and snooze_n asserted together -> ACKED. Alternatively, alert_req dropped the same cycle the ack press matures -> IDLE with ack_pulse=0.
6. Assert rst_n low mid-escalation and mid-debounce -> next cycle state=0 and all outputs 0. A button still held low after reset must be released before it registers a press.
